// File: rtl/prefetch_block_queue.sv
// rtl/prefetch_block_queue.sv - allocation-ordered circular store of prefetched blocks
module prefetch_block_queue #(
    parameter int  LOG_QUEUE_SIZE       = 4,
    parameter int  LOG_BLOCK_DATA_BYTES = 6,
    parameter int  ADDR_BITS            = 64,
    localparam int DEPTH                = 1 << LOG_QUEUE_SIZE,
    localparam int BLK_BITS             = 8 << LOG_BLOCK_DATA_BYTES
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      alloc_valid,
    input  logic [ADDR_BITS-1:0]      alloc_addr,
    output logic                      alloc_ready,
    input  logic                      fill_valid,
    input  logic [ADDR_BITS-1:0]      fill_addr,
    input  logic [BLK_BITS-1:0]       fill_data,
    input  logic                      rd_valid,
    input  logic [ADDR_BITS-1:0]      rd_addr,
    output logic                      rd_resp_valid,
    output logic                      rd_hit,
    output logic                      rd_pending,
    output logic [BLK_BITS-1:0]       rd_data,
    input  logic                      inv_valid,
    input  logic [ADDR_BITS-1:0]      inv_addr,
    input  logic                      flush,
    input  logic [LOG_QUEUE_SIZE-1:0] crs_almostFullSpacer,
    output logic [LOG_QUEUE_SIZE:0]   occupancy,
    output logic [LOG_QUEUE_SIZE:0]   outstanding_cnt,
    output logic                      almost_full,
    output logic [1:0]                errorCode
);
    typedef enum logic [1:0] {S_FREE, S_PEND, S_READY, S_STALE} slot_state_t;

    slot_state_t               r_state [DEPTH];
    logic                      r_out   [DEPTH];
    logic [ADDR_BITS-1:0]      r_addr  [DEPTH];
    logic [BLK_BITS-1:0]       r_data  [DEPTH];
    logic [LOG_QUEUE_SIZE-1:0] r_head, r_tail;
    logic [LOG_QUEUE_SIZE:0]   r_occ;
    logic                      r_rd_resp_valid, r_rd_hit, r_rd_pending;
    logic [BLK_BITS-1:0]       r_rd_data;
    logic [1:0]                r_err;

    logic                      w_alloc_dup, w_rd_found, w_inv_found, w_fill_found;
    logic [LOG_QUEUE_SIZE-1:0] w_rd_idx, w_inv_idx, w_fill_idx, w_rd_off;
    logic [LOG_QUEUE_SIZE:0]   w_out_cnt;
    logic                      w_full, w_alloc_acc, w_rd_consume, w_rd_pend, w_inv_act;
    logic                      w_fill_act, w_reclaim, w_err1, w_err2, w_err3;

    // Live lookups see only PEND/READY; fill search walks from head so the oldest match wins.
    always_comb begin
        logic [LOG_QUEUE_SIZE-1:0] w_j;
        w_alloc_dup  = 1'b0;
        w_rd_found   = 1'b0;
        w_rd_idx     = '0;
        w_inv_found  = 1'b0;
        w_inv_idx    = '0;
        w_fill_found = 1'b0;
        w_fill_idx   = '0;
        w_j          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_state[i] == S_PEND || r_state[i] == S_READY) begin
                if (r_addr[i] == alloc_addr) w_alloc_dup = 1'b1;
                if (r_addr[i] == rd_addr) begin
                    w_rd_found = 1'b1;
                    w_rd_idx   = LOG_QUEUE_SIZE'(i);
                end
                if (r_addr[i] == inv_addr) begin
                    w_inv_found = 1'b1;
                    w_inv_idx   = LOG_QUEUE_SIZE'(i);
                end
            end
        end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_j = r_head + LOG_QUEUE_SIZE'(k);
            if (r_out[w_j] && r_addr[w_j] == fill_addr) begin
                w_fill_found = 1'b1;
                w_fill_idx   = w_j;
            end
        end
    end

    always_comb begin
        w_out_cnt = '0;
        for (int i = 0; i < DEPTH; i++) w_out_cnt = w_out_cnt + (LOG_QUEUE_SIZE + 1)'(r_out[i]);
    end

    assign w_full       = (r_occ == (LOG_QUEUE_SIZE + 1)'(DEPTH));
    assign w_err2       = alloc_valid && !flush && w_full;
    assign w_err1       = alloc_valid && !flush && !w_full && w_alloc_dup;
    assign w_alloc_acc  = alloc_valid && !flush && !w_full && !w_alloc_dup;
    assign w_fill_act   = fill_valid && w_fill_found;
    assign w_err3       = fill_valid && !w_fill_found;
    assign w_rd_consume = rd_valid && !flush && w_rd_found && r_state[w_rd_idx] == S_READY;
    assign w_rd_pend    = rd_valid && !flush && w_rd_found && r_state[w_rd_idx] == S_PEND;
    assign w_rd_off     = w_rd_idx - r_head;
    assign w_inv_act    = inv_valid && !flush && w_inv_found;
    assign w_reclaim    = r_state[r_head] == S_STALE && !r_out[r_head];

    // Later assignments win: fill first, then the retiring operations, reclaim last.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= S_FREE;
                r_out[i]   <= 1'b0;
                r_addr[i]  <= '0;
                r_data[i]  <= '0;
            end
            r_head          <= '0;
            r_tail          <= '0;
            r_occ           <= '0;
            r_rd_resp_valid <= 1'b0;
            r_rd_hit        <= 1'b0;
            r_rd_pending    <= 1'b0;
            r_rd_data       <= '0;
            r_err           <= 2'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_fill_act && w_fill_idx == LOG_QUEUE_SIZE'(i)) begin
                    r_out[i] <= 1'b0;
                    if (r_state[i] == S_PEND) begin
                        r_state[i] <= S_READY;
                        r_data[i]  <= fill_data;
                    end
                end
                if (w_alloc_acc && r_tail == LOG_QUEUE_SIZE'(i)) begin
                    r_state[i] <= S_PEND;
                    r_out[i]   <= 1'b1;
                    r_addr[i]  <= alloc_addr;
                end
                if (flush && r_state[i] != S_FREE) r_state[i] <= S_STALE;
                if (w_rd_consume && LOG_QUEUE_SIZE'(LOG_QUEUE_SIZE'(i) - r_head) <= w_rd_off)
                    r_state[i] <= S_STALE;
                if (w_inv_act && w_inv_idx == LOG_QUEUE_SIZE'(i)) r_state[i] <= S_STALE;
                if (w_reclaim && r_head == LOG_QUEUE_SIZE'(i)) r_state[i] <= S_FREE;
            end
            if (w_alloc_acc) r_tail <= r_tail + 1'b1;
            if (w_reclaim) r_head <= r_head + 1'b1;
            r_occ           <= r_occ + (LOG_QUEUE_SIZE + 1)'(w_alloc_acc) - (LOG_QUEUE_SIZE + 1)'(w_reclaim);
            r_rd_resp_valid <= rd_valid;
            r_rd_hit        <= w_rd_consume;
            r_rd_pending    <= w_rd_pend;
            if (w_rd_consume) r_rd_data <= r_data[w_rd_idx];
            r_err           <= w_err3 ? 2'd3 : w_err2 ? 2'd2 : w_err1 ? 2'd1 : 2'd0;
        end
    end

    assign alloc_ready     = !w_full;
    assign almost_full     = ((LOG_QUEUE_SIZE + 2)'(r_occ) + (LOG_QUEUE_SIZE + 2)'(crs_almostFullSpacer))
                             >= (LOG_QUEUE_SIZE + 2)'(DEPTH);
    assign occupancy       = r_occ;
    assign outstanding_cnt = w_out_cnt;
    assign rd_resp_valid   = r_rd_resp_valid;
    assign rd_hit          = r_rd_hit;
    assign rd_pending      = r_rd_pending;
    assign rd_data         = r_rd_data;
    assign errorCode       = r_err;
endmodule
